// File: rtl/irq_spr_unit.sv
`default_nettype none
// ============================================================================
//  Module      : irq_spr_unit
//  Description : Interrupt cause collection, masking and priority resolution
//                with a registered one-cycle jump-to-ISR pulse issued only at
//                an instruction boundary. Saves the machine state (esr, eca,
//                epc, edata, emode) on entry and restores sr/mode on eret.
//                Owns the special-purpose register file used by movi2s/movs2i.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            rising-edge clock
//    rst_n          asynchronous active-low reset
//    ca_i           cause lines (level, sampled every cycle)
//    instr_done_i   retiring instruction, interrupt boundary
//    eret_i         return-from-exception retires this cycle
//    pc_i           PC of the retiring instruction
//    next_pc_i      PC the core would fetch next
//    ea_i           effective address of the retiring instruction
//    spr_we_i       SPR write strobe
//    spr_addr_i     SPR index: 0 sr,1 esr,2 eca,3 epc,4 edata,5 pto,6 ptl,7 mode
//    spr_wdata_i    SPR write data
//    spr_rdata_o    combinational SPR read data
//    jisr_o         one-cycle jump-to-ISR pulse
//    il_o           index of the serviced cause, valid while jisr_o=1
//    sr_o           status register (interrupt mask)
//    epc_o          saved PC, the eret target
//    pto_o, ptl_o   page-table origin and length
//    mode_o         0 = system, 1 = user
// ============================================================================
module irq_spr_unit #(
    parameter int NUM_CAUSES = 23,
    parameter int NUM_NMI    = 6,
    parameter int REPEAT_LIM = 6,
    parameter int DATA_W     = 32,
    parameter int IL_W       = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_CAUSES-1:0] ca_i,
    input  logic                  instr_done_i,
    input  logic                  eret_i,
    input  logic [DATA_W-1:0]     pc_i,
    input  logic [DATA_W-1:0]     next_pc_i,
    input  logic [DATA_W-1:0]     ea_i,
    input  logic                  spr_we_i,
    input  logic [2:0]            spr_addr_i,
    input  logic [DATA_W-1:0]     spr_wdata_i,
    output logic [DATA_W-1:0]     spr_rdata_o,
    output logic                  jisr_o,
    output logic [IL_W-1:0]       il_o,
    output logic [DATA_W-1:0]     sr_o,
    output logic [DATA_W-1:0]     epc_o,
    output logic [DATA_W-1:0]     pto_o,
    output logic [DATA_W-1:0]     ptl_o,
    output logic                  mode_o
);

    localparam logic [0:0] S_RUN  = 1'b0;
    localparam logic [0:0] S_JISR = 1'b1;

    // Bits below NUM_NMI are non-maskable and never latched.
    localparam logic [NUM_CAUSES-1:0] NMI_MASK =
        NUM_CAUSES'((64'd1 << NUM_NMI) - 64'd1);
    // Bits of eca that can ever be non-zero.
    localparam logic [DATA_W-1:0] ECA_MASK = DATA_W'({NUM_CAUSES{1'b1}});

    logic [0:0]            state_q, state_d;
    logic [IL_W-1:0]       il_q, il_d;
    logic [NUM_CAUSES-1:0] pend_q, pend_d;
    logic [DATA_W-1:0]     sr_q, sr_d;
    logic [DATA_W-1:0]     esr_q, esr_d;
    logic [DATA_W-1:0]     eca_q, eca_d;
    logic [DATA_W-1:0]     epc_q, epc_d;
    logic [DATA_W-1:0]     edata_q, edata_d;
    logic [DATA_W-1:0]     pto_q, pto_d;
    logic [DATA_W-1:0]     ptl_q, ptl_d;
    logic                  mode_q, mode_d;
    logic                  emode_q, emode_d;

    logic [NUM_CAUSES-1:0] act;
    logic [NUM_CAUSES-1:0] mca;
    logic [IL_W-1:0]       il_next;
    logic                  take;
    logic                  do_eret;

    // Latched causes merged with live ones; NMI lines are live only.
    assign act = ((pend_q | ca_i) & ~NMI_MASK) | (ca_i & NMI_MASK);
    assign mca = act & (NMI_MASK | sr_q[NUM_CAUSES-1:0]);

    // Lowest set index wins: scan downward so the last hit is the lowest.
    always_comb begin
        il_next = '0;
        for (int i = NUM_CAUSES - 1; i >= 0; i--) begin
            if (mca[i]) begin
                il_next = IL_W'(i);
            end
        end
    end

    // No new entry while the pulse is out; eret yields to an entry.
    assign take    = (state_q == S_RUN) && instr_done_i && (|mca);
    assign do_eret = (state_q == S_RUN) && eret_i && !take;

    always_comb begin
        state_d = take ? S_JISR : S_RUN;
        il_d    = take ? il_next : il_q;
        // Set wins over clear for a cause asserted on the service edge.
        pend_d  = ((take ? (pend_q & ~mca) : pend_q) | ca_i) & ~NMI_MASK;
        sr_d    = sr_q;
        esr_d   = esr_q;
        eca_d   = eca_q;
        epc_d   = epc_q;
        edata_d = edata_q;
        pto_d   = pto_q;
        ptl_d   = ptl_q;
        mode_d  = mode_q;
        emode_d = emode_q;

        if (spr_we_i) begin
            case (spr_addr_i)
                3'd0:    sr_d    = spr_wdata_i;
                3'd1:    esr_d   = spr_wdata_i;
                3'd2:    eca_d   = spr_wdata_i & ECA_MASK;
                3'd3:    epc_d   = spr_wdata_i;
                3'd4:    edata_d = spr_wdata_i;
                3'd5:    pto_d   = spr_wdata_i;
                3'd6:    ptl_d   = spr_wdata_i;
                default: ;
            endcase
        end

        if (do_eret) begin
            sr_d   = esr_q;
            mode_d = emode_q;
        end

        // Entry overrides any same-cycle write to sr/esr/eca/epc/edata.
        if (take) begin
            esr_d   = sr_q;
            emode_d = mode_q;
            eca_d   = DATA_W'(mca);
            edata_d = ea_i;
            epc_d   = (32'(il_next) < 32'(REPEAT_LIM)) ? pc_i : next_pc_i;
            sr_d    = '0;
            mode_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            il_q    <= '0;
            pend_q  <= '0;
            sr_q    <= '0;
            esr_q   <= '0;
            eca_q   <= '0;
            epc_q   <= '0;
            edata_q <= '0;
            pto_q   <= '0;
            ptl_q   <= '0;
            mode_q  <= 1'b0;
            emode_q <= 1'b0;
        end else begin
            state_q <= state_d;
            il_q    <= il_d;
            pend_q  <= pend_d;
            sr_q    <= sr_d;
            esr_q   <= esr_d;
            eca_q   <= eca_d;
            epc_q   <= epc_d;
            edata_q <= edata_d;
            pto_q   <= pto_d;
            ptl_q   <= ptl_d;
            mode_q  <= mode_d;
            emode_q <= emode_d;
        end
    end

    always_comb begin
        spr_rdata_o = '0;
        case (spr_addr_i)
            3'd0:    spr_rdata_o = sr_q;
            3'd1:    spr_rdata_o = esr_q;
            3'd2:    spr_rdata_o = eca_q;
            3'd3:    spr_rdata_o = epc_q;
            3'd4:    spr_rdata_o = edata_q;
            3'd5:    spr_rdata_o = pto_q;
            3'd6:    spr_rdata_o = ptl_q;
            default: spr_rdata_o = DATA_W'({emode_q, mode_q});
        endcase
    end

    assign jisr_o = (state_q == S_JISR);
    assign il_o   = il_q;
    assign sr_o   = sr_q;
    assign epc_o  = epc_q;
    assign pto_o  = pto_q;
    assign ptl_o  = ptl_q;
    assign mode_o = mode_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_spr_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_irq_spr_unit
//  Description : Directed self-checking bench for irq_spr_unit. Expected
//                values are queued with each stimulus step and compared after
//                the DUT responds.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_spr_unit;

    localparam int NUM_CAUSES = 23;
    localparam int DATA_W     = 32;
    localparam int IL_W       = 5;

    logic                  clk;
    logic                  rst_n;
    logic [NUM_CAUSES-1:0] ca;
    logic                  instr_done;
    logic                  eret;
    logic [DATA_W-1:0]     pc;
    logic [DATA_W-1:0]     next_pc;
    logic [DATA_W-1:0]     ea;
    logic                  spr_we;
    logic [2:0]            spr_addr;
    logic [DATA_W-1:0]     spr_wdata;
    logic [DATA_W-1:0]     spr_rdata;
    logic                  jisr;
    logic [IL_W-1:0]       il;
    logic [DATA_W-1:0]     sr_out;
    logic [DATA_W-1:0]     epc_out;
    logic [DATA_W-1:0]     pto;
    logic [DATA_W-1:0]     ptl;
    logic                  mode_out;

    irq_spr_unit #(
        .NUM_CAUSES (NUM_CAUSES),
        .NUM_NMI    (6),
        .REPEAT_LIM (6),
        .DATA_W     (DATA_W),
        .IL_W       (IL_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ca_i         (ca),
        .instr_done_i (instr_done),
        .eret_i       (eret),
        .pc_i         (pc),
        .next_pc_i    (next_pc),
        .ea_i         (ea),
        .spr_we_i     (spr_we),
        .spr_addr_i   (spr_addr),
        .spr_wdata_i  (spr_wdata),
        .spr_rdata_o  (spr_rdata),
        .jisr_o       (jisr),
        .il_o         (il),
        .sr_o         (sr_out),
        .epc_o        (epc_out),
        .pto_o        (pto),
        .ptl_o        (ptl),
        .mode_o       (mode_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic expect_val(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %h required an entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        spr_addr = a;
        #1;
        d = spr_rdata;
    endtask

    logic [31:0] r;

    initial begin
        rst_n      = 1'b0;
        ca         = '0;
        instr_done = 1'b0;
        eret       = 1'b0;
        pc         = '0;
        next_pc    = '0;
        ea         = '0;
        spr_we     = 1'b0;
        spr_addr   = '0;
        spr_wdata  = '0;
        repeat (2) tick();
        rst_n = 1'b1;

        // Reset state
        expect_val("rst_jisr", 32'd0);  chk(32'(jisr));
        expect_val("rst_sr", 32'd0);    chk(sr_out);
        expect_val("rst_il", 32'd0);    chk(32'(il));
        expect_val("rst_eca", 32'd0);   rd(3'd2, r); chk(r);

        // 1: masked cause latched, no entry until sr unmasks it
        ca = NUM_CAUSES'(1 << 8);
        tick();
        ca = '0;
        repeat (3) tick();
        instr_done = 1'b1;
        expect_val("s1_masked_jisr0", 32'd0);
        tick(); chk(32'(jisr));
        expect_val("s1_masked_jisr1", 32'd0);
        tick(); chk(32'(jisr));
        spr_we = 1'b1; spr_addr = 3'd0; spr_wdata = 32'h0000_0100;
        tick();
        spr_we = 1'b0;
        pc = 32'h80; next_pc = 32'h84; ea = 32'hA5;
        expect_val("s1_jisr", 32'd1);
        expect_val("s1_il", 32'd8);
        expect_val("s1_eca", 32'h100);
        expect_val("s1_epc_next", 32'h84);
        expect_val("s1_edata", 32'hA5);
        expect_val("s1_sr_cleared", 32'd0);
        tick();
        chk(32'(jisr));
        chk(32'(il));
        rd(3'd2, r); chk(r);
        chk(epc_out);
        rd(3'd4, r); chk(r);
        chk(sr_out);
        instr_done = 1'b0;
        expect_val("s1_pulse_once", 32'd0);
        tick(); chk(32'(jisr));

        // 2: NMI bit 3 beats maskable bit 10, repeat-type epc
        spr_we = 1'b1; spr_addr = 3'd0; spr_wdata = 32'hFFFF_FFFF;
        tick();
        spr_we = 1'b0;
        ca = NUM_CAUSES'(32'h408); instr_done = 1'b1;
        pc = 32'h40; next_pc = 32'h44; ea = 32'h0;
        expect_val("s2_jisr", 32'd1);
        expect_val("s2_il", 32'd3);
        expect_val("s2_epc_repeat", 32'h40);
        expect_val("s2_eca", 32'h408);
        expect_val("s2_sr", 32'd0);
        expect_val("s2_mode", 32'd0);
        expect_val("s2_esr", 32'hFFFF_FFFF);
        tick();
        chk(32'(jisr));
        chk(32'(il));
        chk(epc_out);
        rd(3'd2, r); chk(r);
        chk(sr_out);
        chk(32'(mode_out));
        rd(3'd1, r); chk(r);
        ca = '0; instr_done = 1'b0;
        expect_val("s2_jisr_drop", 32'd0);
        tick(); chk(32'(jisr));

        // 3: eret restores sr/mode, epc untouched
        eret = 1'b1;
        expect_val("s3_sr", 32'hFFFF_FFFF);
        expect_val("s3_mode", 32'd0);
        expect_val("s3_jisr", 32'd0);
        expect_val("s3_epc", 32'h40);
        tick();
        chk(sr_out);
        chk(32'(mode_out));
        chk(32'(jisr));
        chk(epc_out);
        eret = 1'b0;

        // 4: entry beats eret and an sr write in the same cycle
        spr_we = 1'b1; spr_addr = 3'd0; spr_wdata = 32'h0000_0C0E;
        expect_val("s4_prep_sr", 32'h0000_0C0E);
        tick(); chk(sr_out);
        ca = NUM_CAUSES'(2); instr_done = 1'b1; eret = 1'b1;
        spr_we = 1'b1; spr_addr = 3'd0; spr_wdata = 32'h5;
        expect_val("s4_jisr", 32'd1);
        expect_val("s4_il", 32'd1);
        expect_val("s4_sr", 32'd0);
        expect_val("s4_esr", 32'h0000_0C0E);
        tick();
        chk(32'(jisr));
        chk(32'(il));
        chk(sr_out);
        rd(3'd1, r); chk(r);

        // 5: pto write during the pulse cycle lands; mode is read-only
        ca = '0; instr_done = 1'b0; eret = 1'b0;
        spr_we = 1'b1; spr_addr = 3'd5; spr_wdata = 32'h1000;
        expect_val("s5_pto", 32'h1000);
        expect_val("s5_jisr_drop", 32'd0);
        tick();
        chk(pto);
        chk(32'(jisr));
        spr_we = 1'b1; spr_addr = 3'd7; spr_wdata = 32'hFFFF_FFFF;
        tick();
        spr_we = 1'b1; spr_addr = 3'd6; spr_wdata = 32'h55;
        tick();
        spr_we = 1'b0;
        expect_val("s5_mode_ro", 32'd0);
        rd(3'd7, r); chk(r);
        expect_val("s5_ptl", 32'h55);
        chk(ptl);

        // 6: asynchronous reset while the pulse is out
        ca = NUM_CAUSES'(1); instr_done = 1'b1;
        expect_val("s6_jisr_before", 32'd1);
        tick(); chk(32'(jisr));
        ca = '0; instr_done = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        expect_val("s6_jisr_async", 32'd0);
        chk(32'(jisr));
        tick();
        rst_n = 1'b1;
        for (int a = 0; a < 8; a++) begin
            expect_val($sformatf("s6_spr%0d", a), 32'd0);
            rd(3'(a), r); chk(r);
        end
        expect_val("s6_pto", 32'd0);  chk(pto);
        expect_val("s6_ptl", 32'd0);  chk(ptl);
        expect_val("s6_epc", 32'd0);  chk(epc_out);

        // Nothing pending after release: no spurious entry
        instr_done = 1'b1;
        expect_val("s6_no_entry", 32'd0);
        tick(); chk(32'(jisr));
        instr_done = 1'b0;

        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
